// File: rtl/bcd_converter.sv
// bcd_converter: sequential 16-bit binary to 4-digit packed BCD converter (double dabble).
//
// A write on WE_I captures DAT_I and runs 16 shift-and-adjust iterations. The
// result is then presented on DAT_O with a one-cycle WE_O strobe. Inputs above
// 9999 cannot be shown in four digits, so they produce 16'hEEEE with OVF_O set.
// One further write may be queued while a conversion runs; later writes replace it.
//
// Ports:
//   clk     - clock, rising edge active
//   rst     - asynchronous reset, active low
//   WE_I    - write strobe, request conversion of DAT_I
//   DAT_I   - unsigned binary value to convert
//   DAT_O   - packed BCD result ([15:12] thousands .. [3:0] units) or 16'hEEEE
//   WE_O    - one-cycle strobe, DAT_O newly valid
//   BUSY_O  - high while converting or delivering a result
//   OVF_O   - high when DAT_O holds the overflow pattern
module bcd_converter (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE_I,
   input  logic [15:0] DAT_I,
   output logic [15:0] DAT_O,
   output logic        WE_O,
   output logic        BUSY_O,
   output logic        OVF_O
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q;
   logic [15:0] bin_q;
   logic [15:0] bcd_q;
   logic [3:0]  cnt_q;
   logic        ovf_q;
   logic [15:0] pend_q;
   logic        pend_vld_q;

   logic [15:0] bcd_adj;
   logic [15:0] bcd_nxt;
   logic [15:0] bin_nxt;
   logic [15:0] start_val;

   // One double-dabble step: correct each digit that would pass 9 after doubling,
   // then shift the BCD/binary pair left as a single 32-bit register.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end else begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
         end
      end
      bcd_nxt = {bcd_adj[14:0], bin_q[15]};
      bin_nxt = {bin_q[14:0], 1'b0};
   end

   // A fresh write always beats the queued value when leaving DONE.
   always_comb begin
      start_val = DAT_I;
      if (state_q == StDone && !WE_I) begin
         start_val = pend_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         DAT_O      <= '0;
         WE_O       <= 1'b0;
         BUSY_O     <= 1'b0;
         OVF_O      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (WE_I) begin
                  bin_q   <= start_val;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= (start_val > 16'd9999);
                  state_q <= StShift;
                  BUSY_O  <= 1'b1;
               end
            end
            StShift: begin
               bcd_q <= bcd_nxt;
               bin_q <= bin_nxt;
               cnt_q <= cnt_q + 4'd1;
               if (WE_I) begin
                  pend_q     <= DAT_I;
                  pend_vld_q <= 1'b1;
               end
               if (cnt_q == 4'd15) begin
                  state_q <= StDone;
                  DAT_O   <= ovf_q ? 16'hEEEE : bcd_nxt;
                  OVF_O   <= ovf_q;
                  WE_O    <= 1'b1;
               end
            end
            StDone: begin
               WE_O <= 1'b0;
               if (WE_I || pend_vld_q) begin
                  bin_q      <= start_val;
                  bcd_q      <= '0;
                  cnt_q      <= '0;
                  ovf_q      <= (start_val > 16'd9999);
                  pend_vld_q <= 1'b0;
                  state_q    <= StShift;
               end else begin
                  state_q <= StIdle;
                  BUSY_O  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               BUSY_O  <= 1'b0;
               WE_O    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: scoreboard bench for bcd_converter.
//
// A reference model watches the bus at each rising edge, decides which writes
// get converted (queued value, last write wins, fresh write wins at DONE) and
// pushes the expected decimal result with its accept cycle. A monitor pops one
// entry per WE_O strobe and checks value, overflow flag and latency, and checks
// BUSY_O and DAT_O/OVF_O hold every cycle.
module tb_bcd_converter;

   logic        clk;
   logic        rst;
   logic        WE_I;
   logic [15:0] DAT_I;
   logic [15:0] DAT_O;
   logic        WE_O;
   logic        BUSY_O;
   logic        OVF_O;

   bcd_converter dut (
      .clk    (clk),
      .rst    (rst),
      .WE_I   (WE_I),
      .DAT_I  (DAT_I),
      .DAT_O  (DAT_O),
      .WE_O   (WE_O),
      .BUSY_O (BUSY_O),
      .OVF_O  (OVF_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] dat;
      logic        ovf;
      logic [31:0] acc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] cyc      = 0;

   // Model state: is a job in flight, when it was accepted, the queued write.
   logic        m_busy     = 1'b0;
   logic [31:0] m_acc      = 0;
   logic [15:0] m_pend     = 0;
   logic        m_pvld     = 1'b0;
   logic [15:0] m_last_dat = 0;
   logic        m_last_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Decimal digits by plain arithmetic.
   function automatic logic [15:0] bcd_of(input int unsigned v);
      if (v > 9999) return 16'hEEEE;
      return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction

   task automatic accept(input logic [15:0] v);
      exp_t e;
      e.dat = bcd_of(32'(v));
      e.ovf = (v > 16'd9999);
      e.acc = cyc;
      sb_q.push_back(e);
      m_acc  = cyc;
      m_busy = 1'b1;
   endtask

   // Reference model: a job occupies 16 shift edges plus one delivery cycle; the
   // edge that ends delivery may start the next job.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         if (!m_busy) begin
            if (WE_I) accept(DAT_I);
         end else if (cyc == m_acc + 17) begin
            if (WE_I) accept(DAT_I);
            else if (m_pvld) accept(m_pend);
            else m_busy = 1'b0;
            m_pvld = 1'b0;
         end else if (WE_I) begin
            m_pend = DAT_I;
            m_pvld = 1'b1;
         end
      end
   end

   // Reset aborts everything in flight.
   always @(negedge rst) begin
      sb_q.delete();
      m_busy     = 1'b0;
      m_pvld     = 1'b0;
      m_last_dat = 16'h0000;
      m_last_ovf = 1'b0;
   end

   // Monitor, sampling 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         if (WE_O) begin
            if (sb_q.size() == 0) begin
               check("unexpected_we_o", 32'(WE_O), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("dat_o", 32'(DAT_O), 32'(e.dat));
               check("ovf_o", 32'(OVF_O), 32'(e.ovf));
               check("latency", cyc - e.acc, 32'd16);
               m_last_dat = e.dat;
               m_last_ovf = e.ovf;
            end
         end else begin
            check("dat_o_hold", 32'(DAT_O), 32'(m_last_dat));
            check("ovf_o_hold", 32'(OVF_O), 32'(m_last_ovf));
            if (sb_q.size() > 0 && cyc > sb_q[0].acc + 16) begin
               check("missing_we_o", 32'(WE_O), 32'd1);
               void'(sb_q.pop_front());
            end
         end
         check("busy_o", 32'(BUSY_O), 32'(m_busy));
      end
   end

   // Stimulus helpers; all called at a falling edge.
   task automatic write(input logic [15:0] v);
      WE_I  = 1'b1;
      DAT_I = v;
      @(negedge clk);
      WE_I  = 1'b0;
      DAT_I = 16'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dat_o"}, 32'(DAT_O), 32'd0);
      check({tag, "_we_o"}, 32'(WE_O), 32'd0);
      check({tag, "_busy_o"}, 32'(BUSY_O), 32'd0);
      check({tag, "_ovf_o"}, 32'(OVF_O), 32'd0);
   endtask

   function automatic logic [15:0] pick_value();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) return 16'($urandom_range(10000, 65535));
      if (r == 1) begin
         case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'd9999;
            2:       return 16'd10000;
            default: return 16'd65535;
         endcase
      end
      return 16'($urandom_range(0, 9999));
   endfunction

   initial begin
      rst   = 1'b0;
      WE_I  = 1'b0;
      DAT_I = 16'h0000;
      idle(3);
      check_reset_outputs("por");
      rst = 1'b1;

      // Single conversions from idle, including digit and overflow boundaries.
      write(16'd1234);   idle(20);
      write(16'd0);      idle(20);
      write(16'd9999);   idle(20);
      write(16'd10000);  idle(20);
      write(16'd65535);  idle(20);
      write(16'd7);      idle(20);

      // Writes during SHIFT: 42 is overwritten by 77, results 17 cycles apart.
      write(16'd5);
      idle(3);
      write(16'd42);
      idle(3);
      write(16'd77);
      idle(40);

      // Reset in the middle of a conversion, then resume.
      write(16'd12);
      idle(8);
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      idle(2);
      rst = 1'b1;
      write(16'd300);
      idle(20);

      // Fresh write during the DONE cycle beats the queued 55.
      write(16'd1000);
      idle(2);
      write(16'd55);
      idle(13);
      write(16'd88);
      idle(40);

      // Randomised traffic with gaps shorter and longer than a conversion.
      for (int i = 0; i < 120; i++) begin
         idle($urandom_range(0, 24));
         write(pick_value());
      end
      idle(60);

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have no parameters; 4-digit width, 16 iterations and overflow pattern are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clk.
REQ-004 WE_I  input  1  write strobe from CPU bus; request to convert DAT_I.
REQ-005 DAT_I  input  16  unsigned binary value to convert.
REQ-006 DAT_O  output  16  packed BCD result, [15:12] thousands ... [3:0] units; feeds display DAT_I.
REQ-007 WE_O  output  1  one-cycle strobe, DAT_O newly valid; feeds display WE_I.
REQ-008 BUSY_O  output  1  high while a conversion is in progress or being delivered.
REQ-009 OVF_O  output  1  high when current DAT_O is the overflow pattern.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-011 IDLE: WE_I=1 at an edge SHALL capture DAT_I into shift register, clear BCD accumulator and iteration counter, go to SHIFT.
REQ-012 Capture SHALL also register ovf = (DAT_I > 9999).
REQ-013 SHIFT: each edge SHALL perform one double-dabble step: every BCD nibble >= 5 gets +3, then accumulator/binary pair shifts left one bit.
REQ-014 Iteration counter SHALL be 4 bits; the 16th SHIFT edge (counter = 15) SHALL go to DONE.
REQ-015 Same edge SHALL load DAT_O = accumulator, or 16'hEEEE if ovf; OVF_O = ovf; WE_O = 1.
REQ-016 Latency: WE_O SHALL be high in the cycle following the 16th edge after the accept edge; exactly one cycle wide.
REQ-017 DONE: next edge SHALL clear WE_O; DAT_O and OVF_O SHALL hold until next DONE load.
REQ-018 BUSY_O SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-019 One-deep pending buffer (16-bit value + valid bit) SHALL exist.
REQ-020 WE_I=1 in SHIFT SHALL write DAT_I to pending and set valid; a later write overwrites (last wins); earlier pending value silently dropped.
REQ-021 DONE exit priority: WE_I=1 -> start with DAT_I, clear pending; else pending valid -> start with pending, clear valid; else -> IDLE.
REQ-022 Starting from DONE SHALL behave exactly as REQ-011/012 (same latency, back-to-back results 17 cycles apart).
REQ-023 Binary input is never truncated; values 10000..65535 SHALL yield 16'hEEEE with OVF_O=1.
REQ-024 DAT_O SHALL never change except at the DONE-load edge or reset.

Reset
REQ-025 rst=0 SHALL force state IDLE, DAT_O=16'h0000, WE_O=0, BUSY_O=0, OVF_O=0, pending valid=0, counter=0.
REQ-026 Reset mid-SHIFT or mid-DONE SHALL abort; no WE_O produced for the aborted value.
REQ-027 First WE_I after rst deasserts SHALL be accepted at the first rising edge with rst=1.

Verification
REQ-028 WE_I pulse, DAT_I=1234 from IDLE -> WE_O one cycle 16 edges later, DAT_O=16'h1234, OVF_O=0, BUSY_O back to 0 one cycle after.
REQ-029 DAT_I=0 -> DAT_O=16'h0000; DAT_I=9999 -> DAT_O=16'h9999, OVF_O=0.
REQ-030 DAT_I=10000, then DAT_I=65535 -> DAT_O=16'hEEEE, OVF_O=1 both times; then DAT_I=7 -> 16'h0007, OVF_O=0.
REQ-031 Write 5, then 42 and 77 during SHIFT -> two WE_O pulses 17 cycles apart: 16'h0005 then 16'h0077; 42 never appears.
REQ-032 Write 12, assert rst=0 at iteration 8 -> outputs zero immediately, no WE_O; after release write 300 -> 16'h0300.
REQ-033 WE_I=88 coinciding with DONE cycle while pending=55 -> 88 converted next, 55 dropped, no idle gap.
